n_output_port_ctrl: RTL and testbench
=====================================

// Module: n_output_port_ctrl
// PURPOSE
//  North output-port controller, directly downstream of the north round-robin processor.
//  Accepts that stage's one-hot grant and locks the north output to the winning input
//  (S/W/E/L) for a whole wormhole packet. Drives the crossbar select and input-buffer pops,
//  and tracks downstream-router credits. Pulses change_order back to the RR registers at packet end.
// PARAMETERS
//  CREDIT_DEPTH  4   downstream input-buffer depth (flits); credit counter reset/max value
//  CNT_W         3   credit counter width; must satisfy 2**CNT_W > CREDIT_DEPTH
// PORTS
//  clk                       in   1  clock; single clock domain
//  reset                     in   1  synchronous, active-high reset
//  rrp_n_priority_to_cs_i    in   1  grant valid from north RR processor
//  rrp_n_priority_s_i        in   1  grant to south input
//  rrp_n_priority_w_i        in   1  grant to west input
//  rrp_n_priority_e_i        in   1  grant to east input
//  rrp_n_priority_l_i        in   1  grant to local input
//  in_valid_i                in   4  head-of-buffer flit valid per input, [3]=S [2]=W [1]=E [0]=L
//  in_tail_i                 in   4  head flit is tail, same bit order
//  credit_return_i           in   1  downstream freed one buffer slot (1 credit)
//  in_pop_o                  out  4  pop owner's input buffer (one-hot or zero)
//  xbar_sel_o                out  3  crossbar select to mux_5to1: 0=none 1=S 2=W 3=E 4=L
//  n_flit_valid_o            out  1  flit presented on north output link this cycle
//  rr_register_change_order_o out 1  one-cycle pulse: rotate RR priority registers
//  credit_cnt_o              out  CNT_W  current credits available
//  grant_err_o               out  1  sticky: multi-hot grant seen while IDLE
//  credit_ovf_o              out  1  sticky: credit_return_i while counter at CREDIT_DEPTH
// BEHAVIOUR
//  Reset values: state=IDLE, owner=none, xbar_sel_o=0, in_pop_o=0, n_flit_valid_o=0,
//   change_order=0, credit_cnt_o=CREDIT_DEPTH, both sticky flags=0. Reset mid-packet
//   drops the lock and restores credits; no pulse is emitted.
//  FSM states:
//   IDLE: if to_cs_i=1 and exactly one grant bit set, latch owner, go to XFER.
//    to_cs_i=1 with zero or multi-hot grants: stay IDLE, grant ignored.
//    Multi-hot grants additionally set grant_err_o.
//   XFER: xbar_sel_o=owner code (registered, stable for the whole packet).
//    send = in_valid_i[owner] & (credit_cnt>0); combinational from state/owner/inputs.
//    send=1 -> in_pop_o[owner]=1, n_flit_valid_o=1.
//    send & in_tail_i[owner] -> next state RELEASE.
//    No send: hold, no pop. Stall is unbounded; no timeout.
//    Grant inputs ignored.
//   RELEASE (1 cycle): xbar_sel_o=0, rr_register_change_order_o=1, go to IDLE.
//    Hence a new grant is accepted at earliest 2 cycles after the tail flit.
//  Latency: grant at cycle t -> first flit may be sent at cycle t+1.
//   Single-flit packet (head=tail) is legal: XFER for 1 cycle, then RELEASE.
//  Credit counter:
//   next = cnt - send + credit_return_i.
//   Simultaneous send and return -> count unchanged.
//   Return at CREDIT_DEPTH with no send -> hold at CREDIT_DEPTH, set credit_ovf_o.
//   Never decrements below 0 (send is gated by cnt>0).
//   Counter runs in all states.
//  change_order pulses only in RELEASE; never pulses twice for one packet.
// STRUCTURE
//  Shared package noc_arb_pkg:
//   typedef enum logic [2:0] {SEL_NONE=0, SEL_S, SEL_W, SEL_E, SEL_L} xbar_sel_t;
//   typedef enum logic [1:0] {OPC_IDLE, OPC_XFER, OPC_RELEASE} opc_state_t;
//   localparam IDX_S=3, IDX_W=2, IDX_E=1, IDX_L=0.
//  One sub-module: credit_counter (CREDIT_DEPTH, CNT_W; dec_i, inc_i, cnt_o, ovf_o).
//   Reusable for the S/W/E output controllers.
// TESTING
//  1 Grant W at t0, W 3-flit packet (tail on 3rd), credits=4 ->
//    pops at t1..t3, xbar_sel=2, change_order pulse at t4, credit_cnt=1.
//  2 Credits exhausted: 6-flit S packet, no returns ->
//    4 flits sent, then stall with in_pop_o=0.
//    One credit_return -> exactly one more flit next cycle.
//  3 Send and credit_return in the same cycle -> credit_cnt unchanged.
//    credit_return at cnt=4 -> cnt stays 4, credit_ovf_o=1.
//  4 Grant S|E (multi-hot) in IDLE -> no lock, grant_err_o=1.
//    Grant L asserted during an E packet -> ignored until E tail + RELEASE.
//  5 Reset asserted mid-packet with credit_cnt=1 ->
//    next cycle IDLE, xbar_sel=0, credit_cnt=4, no change_order pulse.
//  6 Single-flit L packet (valid+tail at t1) -> one pop at t1, pulse at t2.
//    New grant accepted at t3.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port controllers and RR arbiters.
package noc_arb_pkg;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_S    = 3'd1,
        SEL_W    = 3'd2,
        SEL_E    = 3'd3,
        SEL_L    = 3'd4
    } xbar_sel_t;

    typedef enum logic [1:0] {
        OPC_IDLE    = 2'd0,
        OPC_XFER    = 2'd1,
        OPC_RELEASE = 2'd2
    } opc_state_t;

    localparam int unsigned IDX_S  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned IDX_E  = 1;
    localparam int unsigned IDX_L  = 0;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned IDX_W_BITS = 2;

    // Crossbar code for an input index.
    function automatic xbar_sel_t sel_from_idx(input logic [IDX_W_BITS-1:0] idx);
        xbar_sel_t sel;
        case (idx)
            IDX_W_BITS'(IDX_S): sel = SEL_S;
            IDX_W_BITS'(IDX_W): sel = SEL_W;
            IDX_W_BITS'(IDX_E): sel = SEL_E;
            default:            sel = SEL_L;
        endcase
        return sel;
    endfunction

    // Index of the set bit of a one-hot grant vector (callers guarantee one-hot).
    function automatic logic [IDX_W_BITS-1:0] idx_from_onehot(input logic [NUM_IN-1:0] g);
        logic [IDX_W_BITS-1:0] idx;
        idx = IDX_W_BITS'(IDX_L);
        if (g[IDX_S]) idx = IDX_W_BITS'(IDX_S);
        if (g[IDX_W]) idx = IDX_W_BITS'(IDX_W);
        if (g[IDX_E]) idx = IDX_W_BITS'(IDX_E);
        return idx;
    endfunction

endpackage

// File: rtl/n_output_port_ctrl_credit_counter.sv
// Downstream credit counter: decrements on send, increments on returned credit.
module credit_counter
    import noc_arb_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDIT_DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Returns at full depth are dropped and flagged; send is gated upstream by cnt>0.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (dec_i && !inc_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (inc_i && !dec_i) begin
            if (cnt_q == MAX_CNT) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= MAX_CNT;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/n_output_port_ctrl.sv
// North output-port controller: locks the north link to one granted input for a
// whole wormhole packet, drives crossbar select / buffer pops and tracks credits.
module n_output_port_ctrl
    import noc_arb_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rrp_n_priority_to_cs_i,
    input  logic             rrp_n_priority_s_i,
    input  logic             rrp_n_priority_w_i,
    input  logic             rrp_n_priority_e_i,
    input  logic             rrp_n_priority_l_i,
    input  logic [3:0]       in_valid_i,
    input  logic [3:0]       in_tail_i,
    input  logic             credit_return_i,
    output logic [3:0]       in_pop_o,
    output logic [2:0]       xbar_sel_o,
    output logic             n_flit_valid_o,
    output logic             rr_register_change_order_o,
    output logic [CNT_W-1:0] credit_cnt_o,
    output logic             grant_err_o,
    output logic             credit_ovf_o
);

    opc_state_t            state_q, state_d;
    logic [IDX_W_BITS-1:0] owner_q, owner_d;
    xbar_sel_t             xbar_sel_q, xbar_sel_d;
    logic                  change_q, change_d;
    logic                  grant_err_q, grant_err_d;

    logic [NUM_IN-1:0]     grant_vec;
    logic                  grant_onehot;
    logic                  grant_multi;
    logic [CNT_W-1:0]      credit_cnt;
    logic                  send_c;

    assign grant_vec    = {rrp_n_priority_s_i, rrp_n_priority_w_i,
                           rrp_n_priority_e_i, rrp_n_priority_l_i};
    assign grant_multi  = (grant_vec & (grant_vec - NUM_IN'(1))) != '0;
    assign grant_onehot = (grant_vec != '0) && !grant_multi;

    assign send_c = (state_q == OPC_XFER) && in_valid_i[owner_q] && (credit_cnt != '0);

    // Next-state and registered-output logic; change_order is registered so it
    // coincides exactly with the RELEASE cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        xbar_sel_d  = xbar_sel_q;
        change_d    = 1'b0;
        grant_err_d = grant_err_q;
        case (state_q)
            OPC_IDLE: begin
                xbar_sel_d = SEL_NONE;
                if (rrp_n_priority_to_cs_i) begin
                    if (grant_onehot) begin
                        owner_d    = idx_from_onehot(grant_vec);
                        xbar_sel_d = sel_from_idx(idx_from_onehot(grant_vec));
                        state_d    = OPC_XFER;
                    end else if (grant_multi) begin
                        grant_err_d = 1'b1;
                    end
                end
            end
            OPC_XFER: begin
                if (send_c && in_tail_i[owner_q]) begin
                    state_d    = OPC_RELEASE;
                    xbar_sel_d = SEL_NONE;
                    change_d   = 1'b1;
                end
            end
            OPC_RELEASE: begin
                state_d    = OPC_IDLE;
                xbar_sel_d = SEL_NONE;
            end
            default: begin
                state_d    = OPC_IDLE;
                xbar_sel_d = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OPC_IDLE;
            owner_q     <= '0;
            xbar_sel_q  <= SEL_NONE;
            change_q    <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            xbar_sel_q  <= xbar_sel_d;
            change_q    <= change_d;
            grant_err_q <= grant_err_d;
        end
    end

    // Pop the owner's buffer in the same cycle the flit crosses the link.
    always_comb begin
        in_pop_o = '0;
        if (send_c) begin
            in_pop_o[owner_q] = 1'b1;
        end
    end

    credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH),
        .CNT_W        (CNT_W)
    ) u_credit_counter (
        .clk   (clk),
        .reset (reset),
        .dec_i (send_c),
        .inc_i (credit_return_i),
        .cnt_o (credit_cnt),
        .ovf_o (credit_ovf_o)
    );

    assign xbar_sel_o                 = xbar_sel_q;
    assign n_flit_valid_o             = send_c;
    assign rr_register_change_order_o = change_q;
    assign credit_cnt_o               = credit_cnt;
    assign grant_err_o                = grant_err_q;

endmodule

// File: tb/tb_n_output_port_ctrl.sv
// Self-checking bench for n_output_port_ctrl: directed packet scenarios with literal
// expectations plus randomized traffic compared every cycle against a packet-level model.
module tb_n_output_port_ctrl;

    localparam int unsigned CREDIT_DEPTH = 4;
    localparam int unsigned CNT_W        = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             to_cs, g_s, g_w, g_e, g_l;
    logic [3:0]       in_valid, in_tail;
    logic             credit_return;
    logic [3:0]       in_pop;
    logic [2:0]       xbar_sel;
    logic             flit_valid, change_order, grant_err, credit_ovf;
    logic [CNT_W-1:0] credit_cnt;

    always #5 clk = ~clk;

    n_output_port_ctrl #(.CREDIT_DEPTH(CREDIT_DEPTH), .CNT_W(CNT_W)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .rrp_n_priority_to_cs_i     (to_cs),
        .rrp_n_priority_s_i         (g_s),
        .rrp_n_priority_w_i         (g_w),
        .rrp_n_priority_e_i         (g_e),
        .rrp_n_priority_l_i         (g_l),
        .in_valid_i                 (in_valid),
        .in_tail_i                  (in_tail),
        .credit_return_i            (credit_return),
        .in_pop_o                   (in_pop),
        .xbar_sel_o                 (xbar_sel),
        .n_flit_valid_o             (flit_valid),
        .rr_register_change_order_o (change_order),
        .credit_cnt_o               (credit_cnt),
        .grant_err_o                (grant_err),
        .credit_ovf_o               (credit_ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Packet-level model: is the link locked to an owner, or finishing a packet.
    bit m_ready   = 1'b0;
    bit m_locked  = 1'b0;
    bit m_release = 1'b0;
    int m_owner   = 0;
    int m_cred    = CREDIT_DEPTH;
    bit m_err     = 1'b0;
    bit m_ovf     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_send();
        return m_locked && in_valid[m_owner] && (m_cred > 0);
    endfunction

    task automatic drive(input bit rs, input bit cs, input logic [3:0] g,
                         input logic [3:0] v, input logic [3:0] t, input bit ret);
        reset         = rs;
        to_cs         = cs;
        {g_s, g_w, g_e, g_l} = g;
        in_valid      = v;
        in_tail       = t;
        credit_return = ret;
    endtask

    task automatic settle();
        int exp_pop;
        int exp_sel;
        #4;
        if (m_ready) begin
            exp_pop = m_send() ? (1 << m_owner) : 0;
            exp_sel = m_locked ? (4 - m_owner) : 0;
            chk("pop",        int'(in_pop),       exp_pop);
            chk("flit_valid", int'(flit_valid),   int'(m_send()));
            chk("xbar_sel",   int'(xbar_sel),     exp_sel);
            chk("change",     int'(change_order), int'(m_release));
            chk("credit_cnt", int'(credit_cnt),   m_cred);
            chk("grant_err",  int'(grant_err),    int'(m_err));
            chk("credit_ovf", int'(credit_ovf),   int'(m_ovf));
        end
    endtask

    task automatic advance();
        bit         snd;
        int         ones;
        logic [3:0] g;
        @(posedge clk);
        snd  = m_send();
        g    = {g_s, g_w, g_e, g_l};
        ones = $countones(g);
        if (reset) begin
            m_ready = 1'b1; m_locked = 1'b0; m_release = 1'b0;
            m_owner = 0; m_cred = CREDIT_DEPTH; m_err = 1'b0; m_ovf = 1'b0;
        end else begin
            if (snd && !credit_return) m_cred--;
            else if (credit_return && !snd) begin
                if (m_cred == CREDIT_DEPTH) m_ovf = 1'b1;
                else m_cred++;
            end
            if (m_release) begin
                m_release = 1'b0;
            end else if (m_locked) begin
                if (snd && in_tail[m_owner]) begin
                    m_locked  = 1'b0;
                    m_release = 1'b1;
                end
            end else if (to_cs) begin
                if (ones == 1) begin
                    m_locked = 1'b1;
                    for (int i = 0; i < 4; i++) if (g[i]) m_owner = i;
                end else if (ones > 1) begin
                    m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic cyc(input bit rs, input bit cs, input logic [3:0] g,
                       input logic [3:0] v, input logic [3:0] t, input bit ret);
        drive(rs, cs, g, v, t, ret);
        settle();
        advance();
    endtask

    initial begin
        drive(1, 0, 4'b0, 4'b0, 4'b0, 0);
        advance();
        cyc(1, 0, 4'b0, 4'b0, 4'b0, 0);

        // Reset state
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle();
        chk("rst_cnt", int'(credit_cnt), 4);
        chk("rst_sel", int'(xbar_sel), 0);
        chk("rst_flags", int'({grant_err, credit_ovf, change_order}), 0);
        advance();

        // 1: W 3-flit packet
        drive(0, 1, 4'b0100, 4'b0, 4'b0, 0); settle(); chk("s1_t0_pop", int'(in_pop), 0); advance();
        drive(0, 0, 4'b0, 4'b0100, 4'b0, 0); settle();
        chk("s1_t1_pop", int'(in_pop), 4); chk("s1_t1_sel", int'(xbar_sel), 2); advance();
        drive(0, 0, 4'b0, 4'b0100, 4'b0, 0); settle(); chk("s1_t2_pop", int'(in_pop), 4); advance();
        drive(0, 0, 4'b0, 4'b0100, 4'b0100, 0); settle(); chk("s1_t3_pop", int'(in_pop), 4); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle();
        chk("s1_t4_change", int'(change_order), 1); chk("s1_t4_cnt", int'(credit_cnt), 1);
        chk("s1_t4_sel", int'(xbar_sel), 0); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s1_t5_change", int'(change_order), 0); advance();

        // 2: S 6-flit packet runs out of credits
        repeat (3) cyc(0, 0, 4'b0, 4'b0, 4'b0, 1);
        cyc(0, 1, 4'b1000, 4'b0, 4'b0, 0);
        repeat (4) cyc(0, 0, 4'b0, 4'b1000, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b1000, 4'b0, 0); settle();
        chk("s2_stall_pop", int'(in_pop), 0); chk("s2_stall_cnt", int'(credit_cnt), 0);
        chk("s2_stall_sel", int'(xbar_sel), 1); advance();
        drive(0, 0, 4'b0, 4'b1000, 4'b0, 1); settle(); chk("s2_ret_pop", int'(in_pop), 0); advance();
        drive(0, 0, 4'b0, 4'b1000, 4'b0, 0); settle(); chk("s2_5th_pop", int'(in_pop), 8); advance();
        drive(0, 0, 4'b0, 4'b1000, 4'b0, 0); settle(); chk("s2_stall2_pop", int'(in_pop), 0); advance();
        cyc(0, 0, 4'b0, 4'b1000, 4'b1000, 1);
        drive(0, 0, 4'b0, 4'b1000, 4'b1000, 0); settle(); chk("s2_tail_pop", int'(in_pop), 8); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s2_change", int'(change_order), 1); advance();

        // 3: send with simultaneous return, then overflow at full depth
        repeat (2) cyc(0, 0, 4'b0, 4'b0, 4'b0, 1);
        cyc(0, 1, 4'b0010, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0010, 4'b0, 1); settle(); chk("s3_pop", int'(in_pop), 2); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s3_cnt_same", int'(credit_cnt), 2); advance();
        cyc(0, 0, 4'b0, 4'b0010, 4'b0010, 0);
        repeat (4) cyc(0, 0, 4'b0, 4'b0, 4'b0, 1);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle();
        chk("s3_ovf_cnt", int'(credit_cnt), 4); chk("s3_ovf", int'(credit_ovf), 1); advance();

        // 4: multi-hot grant, then L grant ignored during an E packet
        cyc(0, 1, 4'b1010, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle();
        chk("s4_err", int'(grant_err), 1); chk("s4_nolock", int'(xbar_sel), 0); advance();
        cyc(0, 1, 4'b0010, 4'b0, 4'b0, 0);
        repeat (2) begin
            drive(0, 1, 4'b0001, 4'b0011, 4'b0, 0); settle();
            chk("s4_hold_sel", int'(xbar_sel), 3); chk("s4_hold_pop", int'(in_pop), 2); advance();
        end
        cyc(0, 1, 4'b0001, 4'b0011, 4'b0010, 0);
        drive(0, 1, 4'b0001, 4'b0, 4'b0, 0); settle();
        chk("s4_rel_sel", int'(xbar_sel), 0); chk("s4_rel_change", int'(change_order), 1); advance();
        cyc(0, 1, 4'b0001, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s4_l_sel", int'(xbar_sel), 4); advance();
        cyc(0, 0, 4'b0, 4'b0001, 4'b0001, 0);
        cyc(0, 0, 4'b0, 4'b0, 4'b0, 0);
        repeat (4) cyc(0, 0, 4'b0, 4'b0, 4'b0, 1);

        // 5: reset mid-packet with one credit left
        cyc(0, 1, 4'b0010, 4'b0, 4'b0, 0);
        repeat (3) cyc(0, 0, 4'b0, 4'b0010, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s5_pre_cnt", int'(credit_cnt), 1); advance();
        cyc(1, 0, 4'b0, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle();
        chk("s5_sel", int'(xbar_sel), 0); chk("s5_cnt", int'(credit_cnt), 4);
        chk("s5_change", int'(change_order), 0); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s5_change2", int'(change_order), 0); advance();

        // 6: single-flit L packet, new grant two cycles after the tail
        cyc(0, 1, 4'b0001, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0001, 4'b0001, 0); settle(); chk("s6_pop", int'(in_pop), 1); advance();
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s6_change", int'(change_order), 1); advance();
        cyc(0, 1, 4'b0100, 4'b0, 4'b0, 0);
        drive(0, 0, 4'b0, 4'b0, 4'b0, 0); settle(); chk("s6_new_sel", int'(xbar_sel), 2); advance();
        cyc(0, 0, 4'b0, 4'b0100, 4'b0100, 0);
        cyc(0, 0, 4'b0, 4'b0, 4'b0, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] g;
            g = ($urandom_range(1) == 0) ? (4'b0001 << $urandom_range(3)) : 4'($urandom);
            cyc($urandom_range(63) == 0, 1'($urandom), g,
                4'($urandom | $urandom), 4'($urandom & $urandom), $urandom_range(2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
